// File: rtl/maxpool2x2_pair_reducer.sv
// maxpool2x2_pair_reducer
//
// Reduction stage of a 2x2, stride-2 max-pool over a raster pixel stream.
// Each horizontal pixel pair is reduced to its signed maximum. On even rows
// the pair maximum goes into a half-width line buffer. On odd rows it is
// combined with the buffered value from the row above, and one pooled pixel
// is emitted per 2x2 window.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   En         pixel valid; Data_In is accepted on every rising edge with En=1
//   Row_Odd    row-parity flag (1 = odd row); may lag by one accepted pixel
//   Data_In    pixel, raster order, two's-complement
//   Data_Out   pooled pixel; holds its value between pulses
//   Out_Valid  one-cycle pulse marking a valid Data_Out
//   Out_Last   pulses with Out_Valid on the last window of an output row
module maxpool2x2_pair_reducer #(
  parameter int unsigned IMG_SIZE   = 100,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COL_W      = 7
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Row_Odd,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Out_Valid,
  output logic                  Out_Last
);

  localparam int unsigned      HalfSize = IMG_SIZE / 2;
  localparam logic [COL_W-1:0] ColLast  = COL_W'(IMG_SIZE - 1);
  localparam logic [COL_W-2:0] WinLast  = (COL_W - 1)'(HalfSize - 1);

  logic        [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         valid_q, valid_d;
  logic                         last_q, last_d;

  logic signed [DATA_WIDTH-1:0] pix_in;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] buf_rd;
  logic signed [DATA_WIDTH-1:0] win_max;
  logic        [COL_W-2:0]      win_idx;
  logic                         buf_we;

  // Pair maxima of the most recent even row. Never reset: every entry is
  // written on an even row before the following odd row reads it.
  logic signed [DATA_WIDTH-1:0] line_buf [HalfSize];

  assign pix_in  = Data_In;
  assign win_idx = col_cnt_q[COL_W-1:1];

  always_comb begin
    pair_max   = (pix_in > pair_q) ? pix_in : pair_q;
    buf_rd     = line_buf[win_idx];
    win_max    = (buf_rd > pair_max) ? buf_rd : pair_max;

    col_cnt_d  = col_cnt_q;
    pair_d     = pair_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    buf_we     = 1'b0;

    if (En) begin
      col_cnt_d = (col_cnt_q == ColLast) ? '0 : col_cnt_q + COL_W'(1);
      if (!col_cnt_q[0]) begin
        pair_d = pix_in;
      end else if (Row_Odd) begin
        // Row_Odd is only looked at on the second pixel of a pair, by which
        // time a one-pixel-late flag has already settled.
        data_out_d = win_max;
        valid_d    = 1'b1;
        last_d     = (win_idx == WinLast);
      end else begin
        buf_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_cnt_q  <= '0;
      pair_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      pair_q     <= pair_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (buf_we) begin
      line_buf[win_idx] <= pair_max;
    end
  end

  assign Data_Out  = data_out_q;
  assign Out_Valid = valid_q;
  assign Out_Last  = last_q;

endmodule

// File: tb/tb_maxpool2x2_pair_reducer.sv
// Testbench for maxpool2x2_pair_reducer: a 4x4 instance (u_a) for the directed
// scenarios and a 100x100 instance (u_b) for random full frames. A 2x2 window
// reference model pushes expected {last, value} words into a queue per DUT.
module tb_maxpool2x2_pair_reducer;

  localparam int unsigned DW = 16;
  typedef logic signed [DW-1:0] sd_t;

  logic clk;
  logic rst;

  logic          en_a, odd_a, vld_a, last_a;
  logic [DW-1:0] din_a, dout_a;
  logic          en_b, odd_b, vld_b, last_b;
  logic [DW-1:0] din_b, dout_b;

  maxpool2x2_pair_reducer #(.IMG_SIZE(4), .DATA_WIDTH(DW), .COL_W(2)) u_a (
    .Clk(clk), .Rst(rst), .En(en_a), .Row_Odd(odd_a), .Data_In(din_a),
    .Data_Out(dout_a), .Out_Valid(vld_a), .Out_Last(last_a)
  );

  maxpool2x2_pair_reducer #(.IMG_SIZE(100), .DATA_WIDTH(DW), .COL_W(7)) u_b (
    .Clk(clk), .Rst(rst), .En(en_b), .Row_Odd(odd_b), .Data_In(din_b),
    .Data_Out(dout_b), .Out_Valid(vld_b), .Out_Last(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [DW:0] q_a[$];
  logic [DW:0] q_b[$];

  // Reference model state, index 0 = u_a, 1 = u_b.
  int  m_col [2];
  int  m_row [2];
  bit  m_prev_odd [2];
  sd_t m_prow [2][100];
  sd_t m_crow [2][100];

  task automatic model_reset(input int id);
    m_col[id]      = 0;
    m_row[id]      = 0;
    m_prev_odd[id] = 1'b0;
  endtask

  // Row flag presented with a pixel is the parity of the previously accepted
  // pixel's row: the upstream counter is one pixel late at the start of a row.
  task automatic model_pix(input int id, input int img, input sd_t d,
                           output logic odd, output bit push, output logic [DW:0] e);
    int  c;
    int  r;
    sd_t m;
    c    = m_col[id];
    r    = m_row[id];
    odd  = (c == 0) ? m_prev_odd[id] : r[0];
    push = 1'b0;
    e    = '0;
    m_crow[id][c] = d;
    if (r[0] && c[0]) begin
      m = m_prow[id][c-1];
      if (m_prow[id][c] > m)   m = m_prow[id][c];
      if (m_crow[id][c-1] > m) m = m_crow[id][c-1];
      if (d > m)               m = d;
      push = 1'b1;
      e    = {(c == img - 1), m};
    end
    m_prev_odd[id] = r[0];
    if (c == img - 1) begin
      for (int j = 0; j < img; j++) m_prow[id][j] = m_crow[id][j];
      m_col[id] = 0;
      m_row[id] = (r + 1) % img;
    end else begin
      m_col[id] = c + 1;
    end
  endtask

  task automatic pix_a(input sd_t d);
    logic        odd;
    bit          push;
    logic [DW:0] e;
    @(negedge clk);
    model_pix(0, 4, d, odd, push, e);
    if (push) q_a.push_back(e);
    en_a = 1'b1; din_a = d; odd_a = odd;
    @(posedge clk);
    #1 en_a = 1'b0;
  endtask

  task automatic pix_b(input sd_t d);
    logic        odd;
    bit          push;
    logic [DW:0] e;
    @(negedge clk);
    model_pix(1, 100, d, odd, push, e);
    if (push) q_b.push_back(e);
    en_b = 1'b1; din_b = d; odd_b = odd;
    @(posedge clk);
    #1 en_b = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({dout_a, vld_a, last_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_out_a: got %h expected 0", {dout_a, vld_a, last_a});
    end
    n_cmp++;
    if ({dout_b, vld_b, last_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_out_b: got %h expected 0", {dout_b, vld_b, last_b});
    end
    n_cmp++;
    if (u_a.col_cnt_q !== '0 || u_a.pair_q !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got col %0d pair %0d expected 0 0",
               u_a.col_cnt_q, u_a.pair_q);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask

  task automatic test_basic();
    int          got[$];
    int          lit[4];
    logic [DW:0] e;
    lit = '{5, 7, 13, 15};
    for (int i = 0; i < 16; i++) begin
      pix_a(sd_t'(i));
      if (vld_a) begin
        n_cmp++;
        got.push_back(int'($signed(dout_a)));
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL basic_spurious: got %0d expected no output", $signed(dout_a));
        end else begin
          e = q_a.pop_front();
          if ({last_a, dout_a} !== e) begin
            n_fail++;
            $display("FAIL basic_out: got last=%0b %0d expected last=%0b %0d",
                     last_a, $signed(dout_a), e[DW], $signed(e[DW-1:0]));
          end
        end
      end else if (last_a) begin
        n_cmp++;
        n_fail++;
        $display("FAIL basic_last_alone: got 1 expected 0");
      end
    end
    n_cmp++;
    if (got.size() != 4 || got[0] != lit[0] || got[1] != lit[1] ||
        got[2] != lit[2] || got[3] != lit[3]) begin
      n_fail++;
      $display("FAIL basic_values: got %p expected %p", got, lit);
    end
    n_cmp++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL basic_missing: got %0d pending expected 0", q_a.size());
    end
  endtask

  task automatic test_signed();
    sd_t         px[8];
    int          got[$];
    logic [DW:0] e;
    px = '{-16'sd8, -16'sd3, -16'sd1, -16'sd20, -16'sd5, -16'sd9, -16'sd30, -16'sd2};
    for (int i = 0; i < 8; i++) begin
      pix_a(px[i]);
      if (vld_a) begin
        n_cmp++;
        got.push_back(int'($signed(dout_a)));
        e = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if ({last_a, dout_a} !== e) begin
          n_fail++;
          $display("FAIL signed_out: got last=%0b %0d expected last=%0b %0d",
                   last_a, $signed(dout_a), e[DW], $signed(e[DW-1:0]));
        end
      end
    end
    n_cmp++;
    if (got.size() != 2 || got[0] != -3 || got[1] != -1) begin
      n_fail++;
      $display("FAIL signed_values: got %p expected -3 -1", got);
    end
  endtask

  task automatic test_stall();
    int          got[$];
    int          nidle;
    logic [DW:0] e;
    for (int i = 0; i < 16; i++) begin
      nidle = (i % 2 == 0) ? 3 : int'($urandom_range(0, 2));
      pix_a(sd_t'(i));
      if (vld_a) begin
        n_cmp++;
        got.push_back(int'($signed(dout_a)));
        e = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if ({last_a, dout_a} !== e) begin
          n_fail++;
          $display("FAIL stall_out: got last=%0b %0d expected last=%0b %0d",
                   last_a, $signed(dout_a), e[DW], $signed(e[DW-1:0]));
        end
      end
      for (int s = 0; s < nidle; s++) begin
        idle_cycle();
        n_cmp++;
        if (vld_a !== 1'b0 || last_a !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_idle_valid: got %0b%0b expected 00", vld_a, last_a);
        end
      end
    end
    n_cmp++;
    if (got.size() != 4 || got[0] != 5 || got[1] != 7 || got[2] != 13 || got[3] != 15) begin
      n_fail++;
      $display("FAIL stall_values: got %p expected 5 7 13 15", got);
    end
  endtask

  task automatic test_lag();
    logic [DW:0] e;
    for (int i = 0; i < 4; i++) begin
      pix_a(sd_t'(i));
      n_cmp++;
      if (vld_a !== 1'b0) begin
        n_fail++;
        $display("FAIL lag_even_row_valid: got 1 expected 0");
      end
    end
    n_cmp++;
    if (u_a.line_buf[0] !== 16'sd1 || u_a.line_buf[1] !== 16'sd3) begin
      n_fail++;
      $display("FAIL lag_buffer: got %0d %0d expected 1 3", u_a.line_buf[0], u_a.line_buf[1]);
    end
    for (int i = 4; i < 8; i++) begin
      pix_a(sd_t'(i));
      if (vld_a) begin
        n_cmp++;
        e = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if ({last_a, dout_a} !== e) begin
          n_fail++;
          $display("FAIL lag_out: got last=%0b %0d expected last=%0b %0d",
                   last_a, $signed(dout_a), e[DW], $signed(e[DW-1:0]));
        end
      end
    end
    n_cmp++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL lag_missing: got %0d pending expected 0", q_a.size());
    end
  endtask

  task automatic test_mid_reset();
    int          got[$];
    int          lasts;
    logic [DW:0] e;
    for (int i = 0; i < 7; i++) begin
      pix_a(sd_t'(i + 100));
      if (vld_a) begin
        n_cmp++;
        e = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if ({last_a, dout_a} !== e) begin
          n_fail++;
          $display("FAIL mid_pre_out: got %0d expected %0d", $signed(dout_a),
                   $signed(e[DW-1:0]));
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if ({dout_a, vld_a, last_a} !== '0 || u_a.col_cnt_q !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_out: got %h col %0d expected 0 0",
                 {dout_a, vld_a, last_a}, u_a.col_cnt_q);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    n_cmp++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_pending: got %0d expected 0", q_a.size());
    end
    q_a.delete();
    lasts = 0;
    for (int i = 0; i < 16; i++) begin
      pix_a(sd_t'(i));
      if (vld_a) begin
        n_cmp++;
        got.push_back(int'($signed(dout_a)));
        if (last_a) lasts++;
        e = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if ({last_a, dout_a} !== e) begin
          n_fail++;
          $display("FAIL mid_post_out: got last=%0b %0d expected last=%0b %0d",
                   last_a, $signed(dout_a), e[DW], $signed(e[DW-1:0]));
        end
      end
    end
    n_cmp++;
    if (got.size() != 4 || got[0] != 5 || got[1] != 7 || got[2] != 13 ||
        got[3] != 15 || lasts != 2) begin
      n_fail++;
      $display("FAIL mid_post_values: got %p lasts %0d expected 5 7 13 15 lasts 2", got, lasts);
    end
  endtask

  task automatic test_big_frames();
    logic [DW:0] e;
    int          lasts;
    int          outs;
    for (int f = 0; f < 2; f++) begin
      lasts = 0;
      outs  = 0;
      for (int i = 0; i < 10000; i++) begin
        pix_b(sd_t'($urandom));
        if (vld_b) begin
          outs++;
          if (last_b) lasts++;
          e = (q_b.size() != 0) ? q_b.pop_front() : '1;
          if ({last_b, dout_b} !== e) begin
            n_cmp++;
            n_fail++;
            $display("FAIL big_out: got last=%0b %0d expected last=%0b %0d",
                     last_b, $signed(dout_b), e[DW], $signed(e[DW-1:0]));
          end
        end
      end
      n_cmp++;
      if (outs != 2500 || lasts != 50) begin
        n_fail++;
        $display("FAIL big_counts: got %0d outs %0d lasts expected 2500 50", outs, lasts);
      end
    end
    n_cmp++;
    if (q_b.size() != 0) begin
      n_fail++;
      $display("FAIL big_missing: got %0d pending expected 0", q_b.size());
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    en_a = 1'b0; odd_a = 1'b0; din_a = '0;
    en_b = 1'b0; odd_b = 1'b0; din_b = '0;
    rst  = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_lag();
    test_mid_reset();
    test_big_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_pair_reducer.md
Name: maxpool2x2_pair_reducer

Overview:
Downstream consumer of the max-pool row-parity counter, in the maxpool2d 2x2 stride-2 datapath. Takes the same raster pixel stream plus the registered odd-row flag. Reduces each horizontal pixel pair to its maximum and holds even-row pair maxima in a half-width line buffer. On odd rows it combines each pair maximum with the buffered value and emits one pooled pixel per 2x2 window.

Parameters:
IMG_SIZE, 100, image width and height in pixels; must be even and >= 2.
DATA_WIDTH, 16, pixel width; two's-complement signed.
COL_W, 7, column counter width; must satisfy 2^COL_W >= IMG_SIZE.

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  asynchronous, active-low reset.
En  input  1  pixel valid; Data_In is accepted on every rising edge with En=1.
Row_Odd  input  1  row-parity flag from the row counter (1 = odd row); may lag the accepted pixel by one accepted pixel.
Data_In  input  DATA_WIDTH  pixel, raster order.
Data_Out  output  DATA_WIDTH  pooled pixel, signed.
Out_Valid  output  1  one-cycle pulse; Data_Out is valid.
Out_Last  output  1  pulses with Out_Valid on the last pooled pixel of an output row (window index IMG_SIZE/2-1).

Behaviour:
- Reset (Rst=0, async): Col_Cnt=0, Pair_Reg=0, Data_Out=0, Out_Valid=0, Out_Last=0. Line buffer is not reset; it is always written before it is read.
- Col_Cnt advances only on an accepted pixel. It wraps from IMG_SIZE-1 to 0. No frame counter; rows alternate indefinitely.
- Col_Cnt[0]=0 (first pixel of a pair): Pair_Reg <= Data_In. No other state changes.
- Col_Cnt[0]=1 (second pixel of a pair):
  - Pmax = signed max(Pair_Reg, Data_In).
  - k = Col_Cnt>>1.
  - Row_Odd is sampled only on this edge. The one-pixel lag is therefore harmless: the flag is settled by the second pixel of any pair.
  - Row_Odd=0: Buf[k] <= Pmax. Out_Valid stays 0.
  - Row_Odd=1: Data_Out <= signed max(Pmax, Buf[k]); Out_Valid <= 1; Out_Last <= (k == IMG_SIZE/2-1).
- Latency: Data_Out/Out_Valid are registered. They are visible in the cycle after the edge that accepts the odd-column pixel of an odd row.
- Out_Valid/Out_Last are high for exactly one cycle per output, otherwise 0. Data_Out holds its last value between pulses.
- En=0: all state is held, including a half-filled pair in Pair_Reg. Stalls of any length between or inside pairs give identical outputs to an unstalled stream.
- Equal values: either operand may be selected; the result is the same value.
- Comparison is signed over the full DATA_WIDTH. No saturation is needed because the output is always one of the inputs.
- Buffer: IMG_SIZE/2 entries x DATA_WIDTH, one write or one read per accepted odd-column pixel, never both.
- Reset mid-row: restarts at column 0 and discards the pair and row in progress. Upstream is reset together with this block.
- Throughput: one pixel per cycle sustained, no backpressure. Output rate is at most one per 4 accepted pixels on average.

Test Plan:
1. IMG_SIZE=4, DATA_WIDTH=16, En held high, Row_Odd driven with the one-pixel lag, pixels 0..15 raster -> Out_Valid pulses carry 5, 7, 13, 15. Out_Last is high on 7 and 15.
2. Signed data, row0 = -8,-3,-1,-20 and row1 = -5,-9,-30,-2 -> outputs -3, -1. Confirms a signed, not unsigned, compare.
3. Same stream as test 1 with En dropped for 3 cycles between the pixels of every pair and randomly elsewhere -> identical outputs 5, 7, 13, 15. Out_Valid never asserts while En is low.
4. Row_Odd lag check: Row_Odd rises one accepted pixel after row 1 starts -> no output on row 0. Buffer holds 1, 3 before row 1 begins.
5. Assert Rst for 2 cycles after pixel 6 of frame 1, then stream a fresh 4x4 -> outputs, Col_Cnt and Out_Last match a clean run. All outputs read 0 during reset.
6. IMG_SIZE=100, two back-to-back random frames compared against a reference model -> 2x50x50 outputs match. Exactly 50 Out_Last pulses per frame.
